commit_wb_buffer: RTL

// - Receiving end of the execute->commit result interface: each cycle it takes up to 4 ALU

---
 rtl/commit_wb_buffer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/commit_wb_buffer.sv
// Commit-side result buffer: compacts up to NIN execute results per cycle into an in-order
// circular queue, drains NWB per cycle to the register file, and pulses a branch redirect.
module commit_wb_buffer #(
    parameter int DEPTH = 8,
    parameter int NWB   = 2,
    parameter int NIN   = 5,
    parameter int DST_W = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [NIN-1:0]               in_valid,
    input  logic [NIN*DST_W-1:0]         in_dst,
    input  logic [NIN*64-1:0]            in_data,
    input  logic [63:0]                  br_extra,
    output logic                         in_ready,
    output logic [NWB-1:0]               wb_valid,
    output logic [NWB*DST_W-1:0]         wb_dst,
    output logic [NWB*64-1:0]            wb_data,
    output logic                         redirect_valid,
    output logic [63:0]                  redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [63:0]      redirect_pc_q, redirect_pc_d;

    logic [DST_W-1:0] dst_mem  [DEPTH];
    logic [63:0]      data_mem [DEPTH];

    logic [CW:0]      free_slots;
    logic             accept;
    logic [CW:0]      slot_off [NIN];
    logic [CW:0]      nvalid;
    logic [CW:0]      naccept;
    logic [CW:0]      ndrain;

    // Readiness depends only on registered occupancy, never on this cycle's inputs.
    assign free_slots = (CW+1)'(DEPTH) - {1'b0, count_q};
    assign in_ready   = free_slots >= (CW+1)'(NIN);
    assign accept     = in_ready && !flush;

    // Prefix count of valid slots gives each valid slot its compacted offset from tail.
    always_comb begin
        nvalid = '0;
        for (int i = 0; i < NIN; i++) begin
            slot_off[i] = nvalid;
            if (in_valid[i]) begin
                nvalid = nvalid + (CW+1)'(1);
            end
        end
    end

    assign naccept = accept ? nvalid : '0;
    assign ndrain  = ({1'b0, count_q} > (CW+1)'(NWB)) ? (CW+1)'(NWB) : {1'b0, count_q};

    always_comb begin
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(ndrain);
            tail_d  = tail_q + PW'(naccept);
            count_d = CW'({1'b0, count_q} + naccept - ndrain);
            if (accept && in_valid[NIN-1]) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = br_extra;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NIN; i++) begin
            if (accept && in_valid[i]) begin
                dst_mem[tail_q + PW'(slot_off[i])]  <= in_dst[i*DST_W +: DST_W];
                data_mem[tail_q + PW'(slot_off[i])] <= in_data[i*64 +: 64];
            end
        end
    end

    always_comb begin
        wb_valid = '0;
        wb_dst   = '0;
        wb_data  = '0;
        for (int k = 0; k < NWB; k++) begin
            wb_valid[k]                  = ({1'b0, count_q} > (CW+1)'(k)) && !flush;
            wb_dst[k*DST_W +: DST_W]     = dst_mem[head_q + PW'(k)];
            wb_data[k*64 +: 64]          = data_mem[head_q + PW'(k)];
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign count          = count_q;

endmodule
